// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FWFT FIFO pointer/flag controller for a registered-write, async-read dual-port RAM.
// Define FIFO_CTRL_ERR_EN to add sticky ovf_err/udf_err protocol-violation flags.
module fifo_ctrl #(
  parameter int addr_width = 2,
  parameter int data_width = 2,
  parameter int af_level   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  input  logic                  out_ready,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr_wr,
  output logic [addr_width-1:0] ram_addr_rd,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout,
  output logic [addr_width:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic                  ovf_err,
  output logic                  udf_err
`endif
);
  localparam logic [addr_width:0] AF  = (addr_width+1)'(af_level);
  localparam logic [addr_width:0] ONE = (addr_width+1)'(1);
  logic [addr_width:0] r_wr_ptr, r_rd_ptr;
  logic                w_push, w_pop;
  // Extra MSB distinguishes full from empty when the address bits match.
  assign count       = r_wr_ptr - r_rd_ptr;
  assign empty       = r_wr_ptr == r_rd_ptr;
  assign full        = (r_wr_ptr[addr_width-1:0] == r_rd_ptr[addr_width-1:0]) &&
                       (r_wr_ptr[addr_width] != r_rd_ptr[addr_width]);
  assign almost_full = count >= AF;
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign w_push      = in_valid && !full && !rst;
  assign w_pop       = out_ready && !empty;
  assign ram_we      = w_push;
  assign ram_addr_wr = r_wr_ptr[addr_width-1:0];
  assign ram_addr_rd = r_rd_ptr[addr_width-1:0];
  assign ram_din     = in_data;
  assign out_data    = ram_dout;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + ONE;
    end
  end
`ifdef FIFO_CTRL_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      ovf_err <= ovf_err | (in_valid & full);
      udf_err <= udf_err | (out_ready & empty);
    end
  end
`endif
endmodule
